// File: rtl/conv_window_gen.sv
// Streaming FILTER_SIZE x FILTER_SIZE sliding-window generator over a raster pixel stream.
// Optional build macro CONV_WIN_STRIDE2_EN restricts valid windows to stride-2 positions.
module conv_window_gen #(
    parameter int FILTER_SIZE = 5,
    parameter int DATA_BITS   = 8,
    parameter int IMG_WIDTH   = 28,
    parameter int IMG_HEIGHT  = 28
) (
    input  logic                                       clk,
    input  logic                                       rst_n,
    input  logic                                       in_val,
    input  logic [DATA_BITS-1:0]                       pix_in,
    output logic [FILTER_SIZE*FILTER_SIZE*DATA_BITS-1:0] data_out,
    output logic                                       valid,
    output logic                                       frame_done
);
    localparam int FS = FILTER_SIZE;
    localparam int NL = FILTER_SIZE - 1;
    localparam int CW = $clog2(IMG_WIDTH);
    localparam int RW = $clog2(IMG_HEIGHT);

    logic [CW-1:0]        r_col;
    logic [RW-1:0]        r_row;
    logic [DATA_BITS-1:0] r_win   [FS][FS];
    logic [DATA_BITS-1:0] w_lb_rd [NL];
    logic [DATA_BITS-1:0] w_colin [FS];
    logic                 w_col_last, w_row_last, w_win_done;
    logic                 r_valid, r_frame_done;

    // Line buffers: index 0 holds the oldest line, NL-1 the previous line.
    for (genvar gl = 0; gl < NL; gl++) begin : g_lb
        logic [DATA_BITS-1:0] r_mem [IMG_WIDTH];
        logic [DATA_BITS-1:0] w_wr;
        if (gl == NL - 1) begin : g_newest
            assign w_wr = pix_in;
        end else begin : g_older
            assign w_wr = w_lb_rd[gl+1];
        end
        assign w_lb_rd[gl] = r_mem[r_col];
        always_ff @(posedge clk) begin
            if (in_val) r_mem[r_col] <= w_wr;
        end
    end

    for (genvar gr = 0; gr < FS; gr++) begin : g_colin
        if (gr == NL) begin : g_pix
            assign w_colin[gr] = pix_in;
        end else begin : g_buf
            assign w_colin[gr] = w_lb_rd[gr];
        end
        for (genvar gc = 0; gc < FS; gc++) begin : g_pack
            assign data_out[(gr*FS+gc)*DATA_BITS +: DATA_BITS] = r_win[gr][gc];
        end
    end

    assign w_col_last = (r_col == CW'(IMG_WIDTH - 1));
    assign w_row_last = (r_row == RW'(IMG_HEIGHT - 1));
`ifdef CONV_WIN_STRIDE2_EN
    // (pos - (FS-1)) even is the same as pos LSB matching the LSB of FS-1.
    localparam logic FS_PAR = 1'((FS - 1) % 2);
    assign w_win_done = (r_row >= RW'(FS - 1)) && (r_col >= CW'(FS - 1)) &&
                        (r_row[0] == FS_PAR) && (r_col[0] == FS_PAR);
`else
    assign w_win_done = (r_row >= RW'(FS - 1)) && (r_col >= CW'(FS - 1));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < FS; r++)
                for (int c = 0; c < FS; c++)
                    r_win[r][c] <= '0;
        end else if (in_val) begin
            for (int r = 0; r < FS; r++) begin
                for (int c = 0; c < FS - 1; c++)
                    r_win[r][c] <= r_win[r][c+1];
                r_win[r][FS-1] <= w_colin[r];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_col        <= '0;
            r_row        <= '0;
            r_valid      <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_valid      <= in_val && w_win_done;
            r_frame_done <= in_val && w_col_last && w_row_last;
            if (in_val) begin
                if (w_col_last) begin
                    r_col <= '0;
                    r_row <= w_row_last ? '0 : r_row + 1'b1;
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

    assign valid      = r_valid;
    assign frame_done = r_frame_done;
endmodule

// File: tb/tb_conv_window_gen.sv
// Bench for conv_window_gen: default 28x28/5x5 instance and a small 8x6/3x3 instance,
// checked against an image-array model through a window scoreboard plus spot-value tables.
module tb_conv_window_gen;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic         iv_a = 1'b0, iv_b = 1'b0;
    logic [7:0]   pix_a = '0, pix_b = '0;
    logic [199:0] do_a;
    logic [71:0]  do_b;
    logic         v_a, v_b, fd_a, fd_b;

    conv_window_gen u_a (
        .clk(clk), .rst_n(rst_n), .in_val(iv_a), .pix_in(pix_a),
        .data_out(do_a), .valid(v_a), .frame_done(fd_a));

    conv_window_gen #(.FILTER_SIZE(3), .DATA_BITS(8), .IMG_WIDTH(8), .IMG_HEIGHT(6)) u_b (
        .clk(clk), .rst_n(rst_n), .in_val(iv_b), .pix_in(pix_b),
        .data_out(do_b), .valid(v_b), .frame_done(fd_b));

`ifdef CONV_WIN_STRIDE2_EN
    localparam int N_BIG = 144, N_SMALL = 6, W1_E24 = 118, ROW6_WIN = 12, LAST_E24 = 242;
`else
    localparam int N_BIG = 576, N_SMALL = 24, W1_E24 = 117, ROW6_WIN = 48, LAST_E24 = 15;
`endif

    typedef struct {
        int scen;
        int win;
        int elem;
        int exp_val;
        int exp_pix;   // completing pixel index, -1 = not checked
    } spot_t;
    spot_t tbl[$];

    int checks = 0;
    int errors = 0;
    logic [199:0] sb[$];
    logic [199:0] cap[$];
    logic [199:0] ref1[$];
    int           cap_pix[$];
    int nfd, pix_idx, mrow, mcol;
    logic [7:0] img [0:27][0:27];

    task automatic chk(input string nm, input logic [199:0] act, input logic [199:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    task automatic clear_run();
        sb.delete(); cap.delete(); cap_pix.delete();
        nfd = 0; pix_idx = 0;
    endtask

    task automatic step(input bit sel, input bit v, input logic [7:0] p);
        int fs, w, h;
        bit ev, efd, av, afd;
        logic [199:0] ew, ad;
        fs = sel ? 3 : 5; w = sel ? 8 : 28; h = sel ? 6 : 28;
        ev = 1'b0; efd = 1'b0; ew = '0;
        if (v) begin
            img[mrow][mcol] = p;
            ev = (mrow >= fs - 1) && (mcol >= fs - 1);
`ifdef CONV_WIN_STRIDE2_EN
            ev = ev && ((mrow - fs + 1) % 2 == 0) && ((mcol - fs + 1) % 2 == 0);
`endif
            efd = (mrow == h - 1) && (mcol == w - 1);
            if (ev) begin
                for (int r = 0; r < fs; r++)
                    for (int c = 0; c < fs; c++)
                        ew[(r*fs+c)*8 +: 8] = img[mrow-fs+1+r][mcol-fs+1+c];
                sb.push_back(ew);
            end
            if (mcol == w - 1) begin
                mcol = 0;
                mrow = (mrow == h - 1) ? 0 : mrow + 1;
            end else mcol++;
        end
        iv_a = v && !sel; iv_b = v && sel; pix_a = p; pix_b = p;
        @(posedge clk); #1;
        av  = sel ? v_b : v_a;
        afd = sel ? fd_b : fd_a;
        ad  = sel ? {128'b0, do_b} : do_a;
        chk("valid", {199'b0, av}, {199'b0, ev});
        chk("frame_done", {199'b0, afd}, {199'b0, efd});
        if (av) begin
            cap.push_back(ad);
            cap_pix.push_back(pix_idx);
            if (sb.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_window actual=%0h required=none", ad);
            end else chk("window", ad, sb.pop_front());
        end
        if (afd) nfd++;
        if (v) pix_idx++;
        iv_a = 1'b0; iv_b = 1'b0;
    endtask

    task automatic run_frame(input bit sel, input int offset, input int maxgap);
        int w, h, g;
        w = sel ? 8 : 28; h = sel ? 6 : 28;
        for (int r = 0; r < h; r++)
            for (int c = 0; c < w; c++) begin
                if (maxgap > 0 && (r | c) != 0) begin
                    g = $urandom_range(0, maxgap);
                    for (int k = 0; k < g; k++) step(sel, 1'b0, 8'h00);
                end
                step(sel, 1'b1, 8'((r*w + c + offset) % 256));
            end
    endtask

    task automatic apply_spots(input int scen);
        logic [199:0] wv;
        foreach (tbl[i]) begin
            if (tbl[i].scen != scen) continue;
            if (tbl[i].win >= cap.size()) begin
                checks++; errors++;
                $display("FAIL spot_missing scen=%0d win=%0d actual_count=%0d", scen, tbl[i].win, cap.size());
                continue;
            end
            wv = cap[tbl[i].win];
            chk($sformatf("spot s%0d w%0d e%0d", scen, tbl[i].win, tbl[i].elem),
                {192'b0, wv[tbl[i].elem*8 +: 8]}, 200'(tbl[i].exp_val));
            if (tbl[i].exp_pix >= 0)
                chk($sformatf("spot_pix s%0d w%0d", scen, tbl[i].win),
                    200'(cap_pix[tbl[i].win]), 200'(tbl[i].exp_pix));
        end
    endtask

    task automatic cmp_ref(input string nm, input int base);
        for (int i = 0; i < ref1.size(); i++) begin
            if (base + i >= cap.size()) begin
                checks++; errors++;
                $display("FAIL %s_short actual=%0d required=%0d", nm, cap.size(), base + ref1.size());
                return;
            end
            chk(nm, cap[base+i], ref1[i]);
        end
    endtask

    initial begin
        tbl.push_back('{1, 0, 0, 0, 116});
        tbl.push_back('{1, 0, 4, 4, -1});
        tbl.push_back('{1, 0, 20, 112, -1});
        tbl.push_back('{1, 0, 24, 116, -1});
        tbl.push_back('{1, 1, 24, W1_E24, -1});
        tbl.push_back('{1, ROW6_WIN, 24, 172, -1});
        tbl.push_back('{1, N_BIG-1, 24, LAST_E24, 783});
        tbl.push_back('{3, N_BIG, 0, 100, 900});
        tbl.push_back('{3, N_BIG, 24, 216, -1});
        tbl.push_back('{6, 0, 0, 0, 18});
        tbl.push_back('{6, 0, 8, 18, -1});

        mrow = 0; mcol = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_valid", {199'b0, v_a}, '0);
        chk("reset_frame_done", {199'b0, fd_a}, '0);
        chk("reset_data", do_a, '0);
        rst_n = 1'b1;

        // Ramp frame, continuous input
        clear_run();
        run_frame(1'b0, 0, 0);
        chk("s1_count", 200'(cap.size()), 200'(N_BIG));
        chk("s1_frame_done", 200'(nfd), 200'd1);
        apply_spots(1);
        ref1 = cap;

        // Random idle gaps
        clear_run();
        run_frame(1'b0, 0, 5);
        chk("s2_count", 200'(cap.size()), 200'(N_BIG));
        cmp_ref("s2_seq", 0);

        // Back-to-back frames
        clear_run();
        run_frame(1'b0, 0, 0);
        run_frame(1'b0, 100, 0);
        chk("s3_count", 200'(cap.size()), 200'(2*N_BIG));
        chk("s3_frame_done", 200'(nfd), 200'd2);
        apply_spots(3);
        cmp_ref("s3_seq", 0);

        // Reset mid-frame, asserted between clock edges
        clear_run();
        for (int i = 0; i <= 300; i++) step(1'b0, 1'b1, 8'(((i / 28) * 28 + (i % 28)) % 256));
        chk("s4_pre_valid", {199'b0, v_a}, 200'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("s4_rst_valid", {199'b0, v_a}, '0);
        chk("s4_rst_frame_done", {199'b0, fd_a}, '0);
        chk("s4_rst_data", do_a, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mrow = 0; mcol = 0;
        clear_run();
        run_frame(1'b0, 0, 0);
        chk("s4_count", 200'(cap.size()), 200'(N_BIG));
        apply_spots(1);
        cmp_ref("s4_seq", 0);

        // Small-parameter instance
        clear_run();
        mrow = 0; mcol = 0;
        run_frame(1'b1, 0, 0);
        chk("s6_count", 200'(cap.size()), 200'(N_SMALL));
        chk("s6_frame_done", 200'(nfd), 200'd1);
        apply_spots(6);

        chk("sb_empty", 200'(sb.size()), '0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/conv_window_gen.md
# conv_window_gen

Streaming sliding-window generator that feeds `conv_calc`. It accepts one unsigned pixel per cycle in raster order, buffers FILTER_SIZE-1 image lines, and presents each complete FILTER_SIZE×FILTER_SIZE window on a flattened bus with a one-cycle `valid` pulse. The bus packing matches `conv_calc.data_in`, so `data_out`/`valid` connect directly to `data_in`/`in_val`. Valid (unpadded) convolution only.

## Interface
- `FILTER_SIZE`, default 5: window edge length.
- `DATA_BITS`, default 8: pixel width (unsigned).
- `IMG_WIDTH`, default 28: pixels per line, must be ≥ FILTER_SIZE.
- `IMG_HEIGHT`, default 28: lines per frame, must be ≥ FILTER_SIZE.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_val` in 1: `pix_in` is valid this cycle; the pixel is accepted. There is no backpressure.
- `pix_in` in DATA_BITS: pixel, raster order, top-left first.
- `data_out` out FILTER_SIZE*FILTER_SIZE*DATA_BITS: window; element i = r*FILTER_SIZE+c at `[i*DATA_BITS +: DATA_BITS]`, r=0 top (oldest line), c=0 leftmost (oldest column).
- `valid` out 1: `data_out` holds a complete window this cycle.
- `frame_done` out 1: one-cycle pulse after the last pixel of a frame is accepted.

## Operation
- Position counters: `col` runs 0..IMG_WIDTH-1 and `row` runs 0..IMG_HEIGHT-1. Each counter is $clog2 wide and advances only on accepted pixels. `col` wraps to 0 and increments `row`. At (IMG_HEIGHT-1, IMG_WIDTH-1) both counters wrap to 0, and the next accepted pixel starts a new frame.
- Storage: FILTER_SIZE-1 line buffers, each IMG_WIDTH×DATA_BITS, addressed by `col`, plus a FILTER_SIZE×FILTER_SIZE register window.
- On each accepted pixel:
  - Every window row shifts left by one.
  - Window row FILTER_SIZE-1, column FILTER_SIZE-1, loads `pix_in`.
  - Window row r < FILTER_SIZE-1, column FILTER_SIZE-1, loads the pixel from line (row-FILTER_SIZE+1+r) at the current `col`.
  - The line buffers cascade: the newest buffer takes `pix_in` and each older buffer takes the next-newer buffer's read value. All writes go to address `col`.
- Window completion: the accepted pixel at (row, col) completes a window iff row ≥ FILTER_SIZE-1 and col ≥ FILTER_SIZE-1. Output count per frame is (IMG_WIDTH-FILTER_SIZE+1)×(IMG_HEIGHT-FILTER_SIZE+1), which is 576 at the defaults.
- Columns from a previous line never appear in a valid window, because `valid` is gated by `col`. Window registers may hold stale data at col < FILTER_SIZE-1.
- Lines from a previous frame never appear in a valid window, because `valid` is gated by `row`.
- Reset (asynchronous, including mid-frame):
  - `col`=0, `row`=0, `valid`=0, `frame_done`=0, `data_out`=0 immediately.
  - Line buffer contents are not cleared; they are don't-care.
  - The first accepted pixel after reset release is (0,0).

## Timing
- Latency is 1 cycle. `valid` and the window appear on the cycle after the rising edge that accepts the completing pixel.
- `valid` is high for exactly one cycle per completed window. With `in_val` low, `valid`=0 and `data_out` holds its last value.
- Back-to-back `in_val` gives one window per cycle. Gaps of any length are tolerated; state simply holds.
- `frame_done` rises one cycle after (IMG_HEIGHT-1, IMG_WIDTH-1) is accepted. With the macro absent it coincides with the last `valid`.
- The first pixel of the next frame may be accepted on the cycle immediately after the last pixel of the current frame.

## Configuration
- `CONV_WIN_STRIDE2_EN`: when defined, `valid` additionally requires (row-FILTER_SIZE+1) even and (col-FILTER_SIZE+1) even.
  - This gives stride-2 output: 144 windows at the defaults.
  - Datapath, latency and `frame_done` are unchanged.
- When undefined, the block runs at stride 1 as described above.

## Test plan
All scenarios use the default parameters unless stated.

1. **Ramp frame.** Continuous `in_val`, pixel(r,c) = (r*28+c) mod 256.
   - Exactly 576 `valid` pulses.
   - First pulse is one cycle after pixel index 116 is accepted, with element0=0, element4=4, element20=112, element24=116.
   - Last window has element24=(27*28+27) mod 256=15.
   - `frame_done` coincides with the last pulse.
2. **Random in_val gaps.** Same ramp with 0–5 idle cycles between pixels.
   - Identical 576-window sequence.
   - Each `valid` occurs exactly one cycle after its completing pixel.
   - `valid`=0 on every idle cycle.
3. **Back-to-back frames.** Two ramp frames with no gap, frame 2 offset by +100 mod 256.
   - Frame 2's first window is element0=100, element24=216, one cycle after frame-2 pixel 116.
   - Exactly 1152 windows in total.
   - Two `frame_done` pulses.
4. **Reset mid-frame.** Assert `rst_n`=0 asynchronously after pixel 300.
   - `valid`, `frame_done` and `data_out` go to 0 within the same cycle.
   - After release, a fresh ramp frame reproduces scenario 1 exactly.
5. **Stride-2 build.** `CONV_WIN_STRIDE2_EN` defined, ramp frame.
   - 144 windows.
   - Windows complete at pixels 116, 118, …; the second window has element24=118.
   - The first window of row 6 has element24=172.
6. **Small parameters.** FILTER_SIZE=3, IMG_WIDTH=8, IMG_HEIGHT=6, pixel=r*8+c.
   - 24 windows.
   - First window has element0=0, element8=18.
   - `data_out` is 72 bits.
